// File: rtl/memx_stream_reader.sv
// X-vector memory read engine: walks a word range and streams
// the packed elements of each word one per beat, LSB element first.
module memx_stream_reader #(
    parameter int element_width          = 64,
    parameter int memories_address_width = 20,
    parameter int no_of_units            = 8
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     start,
    input  logic [memories_address_width-1:0]        base_address,
    input  logic [memories_address_width-1:0]        length,
    output logic [memories_address_width-1:0]        mem_rd_addr,
    input  logic [no_of_units*element_width-1:0]     mem_rd_data,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [element_width-1:0]                 out_data,
    output logic [$clog2(no_of_units)-1:0]           out_elem_index,
    output logic                                     out_last,
    output logic                                     busy,
    output logic                                     done
);

    localparam int AW = memories_address_width;
    localparam int DW = no_of_units * element_width;
    localparam int IW = $clog2(no_of_units);
    localparam logic [IW-1:0] LAST_IDX = IW'(no_of_units - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EMIT,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] rem_q, rem_d;
    logic [DW-1:0] word_q, word_d;
    logic [IW-1:0] idx_q, idx_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            word_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        word_d  = word_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        addr_d  = base_address;
                        rem_d   = length;
                        state_d = FETCH;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            FETCH: begin
                word_d  = mem_rd_data;
                addr_d  = addr_q + 1'b1;
                rem_d   = rem_q - 1'b1;
                idx_d   = '0;
                state_d = EMIT;
            end
            EMIT: begin
                if (out_ready) begin
                    if (idx_q != LAST_IDX) begin
                        idx_d = idx_q + 1'b1;
                    end else if (rem_q != '0) begin
                        // next word is already addressed: load it with no bubble
                        word_d = mem_rd_data;
                        addr_d = addr_q + 1'b1;
                        rem_d  = rem_q - 1'b1;
                        idx_d  = '0;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_rd_addr    = addr_q;
    assign out_valid      = (state_q == EMIT);
    assign out_data       = word_q[idx_q*element_width +: element_width];
    assign out_elem_index = idx_q;
    assign out_last       = out_valid && (rem_q == '0) && (idx_q == LAST_IDX);
    assign busy           = (state_q != IDLE);
    assign done           = (state_q == DONE);

endmodule

// File: tb/tb_memx_stream_reader.sv
// Directed bench for memx_stream_reader with a computed memory image.
module tb_memx_stream_reader;

    localparam int W  = 64;
    localparam int AW = 20;
    localparam int N  = 8;
    localparam int DW = N * W;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_address;
    logic [AW-1:0] length;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [2:0]    out_elem_index;
    logic          out_last;
    logic          busy;
    logic          done;

    int errors = 0;
    int checks = 0;

    memx_stream_reader #(
        .element_width(W),
        .memories_address_width(AW),
        .no_of_units(N)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .base_address(base_address),
        .length(length),
        .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_elem_index(out_elem_index),
        .out_last(out_last),
        .busy(busy),
        .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // word 5 holds 1..8; every other word encodes its address and slot
    function automatic logic [W-1:0] elem(input logic [AW-1:0] a, input int e);
        logic [W-1:0] v;
        if (a == 20'd5) v = 64'(e + 1);
        else v = {12'hABC, a, 24'h0, 8'(e)};
        return v;
    endfunction

    always_comb begin
        mem_rd_data = '0;
        for (int e = 0; e < N; e++)
            mem_rd_data[e*W +: W] = elem(mem_rd_addr, e);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_cmd(input logic [AW-1:0] b, input logic [AW-1:0] l);
        start = 1'b1;
        base_address = b;
        length = l;
        step();
        start = 1'b0;
    endtask

    initial begin
        logic [AW-1:0] a;
        int cnt;
        bit seen;
        bit hs;
        rst_n = 1'b0;
        start = 1'b0;
        base_address = '0;
        length = '0;
        out_ready = 1'b0;
        step();
        step();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_addr", 64'(mem_rd_addr), 64'd0);
        chk("rst_last", 64'(out_last), 64'd0);
        rst_n = 1'b1;
        step();

        // basic single word
        out_ready = 1'b1;
        start_cmd(20'd5, 20'd1);
        chk("b_fetch_valid", 64'(out_valid), 64'd0);
        chk("b_fetch_busy", 64'(busy), 64'd1);
        chk("b_fetch_addr", 64'(mem_rd_addr), 64'd5);
        step();
        for (int e = 0; e < N; e++) begin
            chk("b_valid", 64'(out_valid), 64'd1);
            chk("b_data", out_data, 64'(e + 1));
            chk("b_idx", 64'(out_elem_index), 64'(e));
            chk("b_last", 64'(out_last), 64'(e == 7));
            chk("b_done_low", 64'(done), 64'd0);
            step();
        end
        chk("b_done", 64'(done), 64'd1);
        chk("b_done_busy", 64'(busy), 64'd1);
        chk("b_done_valid", 64'(out_valid), 64'd0);
        step();
        chk("b_idle_done", 64'(done), 64'd0);
        chk("b_idle_busy", 64'(busy), 64'd0);

        // multi word, no bubbles
        start_cmd(20'd10, 20'd3);
        chk("m_fetch_addr", 64'(mem_rd_addr), 64'd10);
        step();
        for (int b = 0; b < 24; b++) begin
            a = 20'(10 + b / 8);
            chk("m_valid", 64'(out_valid), 64'd1);
            chk("m_data", out_data, elem(a, b % 8));
            chk("m_idx", 64'(out_elem_index), 64'(b % 8));
            chk("m_addr", 64'(mem_rd_addr), 64'(11 + b / 8));
            chk("m_last", 64'(out_last), 64'(b == 23));
            step();
        end
        chk("m_done", 64'(done), 64'd1);
        step();

        // backpressure with ready pattern 1,0,0,1
        start_cmd(20'd20, 20'd1);
        step();
        cnt = 0;
        seen = 1'b0;
        for (int c = 0; c < 64 && !seen; c++) begin
            out_ready = (c % 4 == 0) || (c % 4 == 3);
            if (done) begin
                seen = 1'b1;
            end else begin
                chk("bp_valid", 64'(out_valid), 64'd1);
                chk("bp_data", out_data, elem(20'd20, cnt));
                chk("bp_idx", 64'(out_elem_index), 64'(cnt));
                chk("bp_last", 64'(out_last), 64'(cnt == 7));
                hs = out_valid && out_ready;
                step();
                if (hs) cnt++;
            end
        end
        chk("bp_done_seen", 64'(seen), 64'd1);
        chk("bp_count", 64'(cnt), 64'd8);
        out_ready = 1'b1;
        step();

        // zero length
        start_cmd(20'd3, 20'd0);
        chk("z_done", 64'(done), 64'd1);
        chk("z_valid", 64'(out_valid), 64'd0);
        chk("z_busy", 64'(busy), 64'd1);
        step();
        chk("z_idle_done", 64'(done), 64'd0);
        chk("z_idle_valid", 64'(out_valid), 64'd0);
        chk("z_idle_busy", 64'(busy), 64'd0);

        // start while busy is ignored
        start_cmd(20'd30, 20'd2);
        step();
        for (int b = 0; b < 16; b++) begin
            a = 20'(30 + b / 8);
            chk("s_valid", 64'(out_valid), 64'd1);
            chk("s_data", out_data, elem(a, b % 8));
            chk("s_last", 64'(out_last), 64'(b == 15));
            if (b == 3) begin
                start_cmd(20'd99, 20'd1);
            end else begin
                step();
            end
        end
        chk("s_done", 64'(done), 64'd1);
        step();
        chk("s_idle_busy", 64'(busy), 64'd0);
        step();
        chk("s_no_restart", 64'(out_valid), 64'd0);
        chk("s_addr_held", 64'(mem_rd_addr), 64'd32);

        // address wrap
        start_cmd(20'hFFFFF, 20'd2);
        chk("w_fetch_addr", 64'(mem_rd_addr), 64'hFFFFF);
        step();
        chk("w_addr0", 64'(mem_rd_addr), 64'h0);
        for (int b = 0; b < 16; b++) begin
            a = (b < 8) ? 20'hFFFFF : 20'h0;
            chk("w_data", out_data, elem(a, b % 8));
            step();
        end
        chk("w_done", 64'(done), 64'd1);
        chk("w_addr_end", 64'(mem_rd_addr), 64'h1);
        step();

        // reset in the middle of a transfer
        start_cmd(20'd40, 20'd2);
        step();
        for (int b = 0; b < 4; b++) begin
            chk("r_data", out_data, elem(20'd40, b));
            step();
        end
        chk("r_beat5", out_data, elem(20'd40, 4));
        rst_n = 1'b0;
        step();
        chk("r_valid", 64'(out_valid), 64'd0);
        chk("r_busy", 64'(busy), 64'd0);
        chk("r_done", 64'(done), 64'd0);
        chk("r_addr", 64'(mem_rd_addr), 64'd0);
        rst_n = 1'b1;
        step();
        chk("r_after_valid", 64'(out_valid), 64'd0);
        chk("r_after_done", 64'(done), 64'd0);
        step();
        chk("r_after2_done", 64'(done), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/memx_stream_reader.md
Name: memx_stream_reader

Overview:
- Read-side engine for the X-vector memory.
- On a start command it walks a contiguous range of wide memory words, starting at a base address, for a given length.
- Each wide word (no_of_units packed elements) is unpacked into single elements, streamed one per beat over a valid/ready interface into the downstream datapath.
- Drives the memory's combinational read port: data for a read address is valid in the same cycle.

Parameters:
- element_width, 64, bits per element.
- memories_address_width, 20, memory word address width.
- no_of_units, 8, elements packed per memory word; must be ≥2.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  one-cycle command strobe; sampled only in IDLE.
- base_address  input  memories_address_width  first word address; sampled with start.
- length  input  memories_address_width  number of words to read; sampled with start.
- mem_rd_addr  output  memories_address_width  read address to memory.
- mem_rd_data  input  no_of_units*element_width  combinational read data for mem_rd_addr.
- out_valid  output  1  element valid.
- out_ready  input  1  downstream accepts element.
- out_data  output  element_width  current element.
- out_elem_index  output  clog2(no_of_units)  element position within the current word.
- out_last  output  1  final element of the whole transfer; qualified by out_valid.
- busy  output  1  high from accepted start until DONE exits.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (rst_n=0 at posedge):
  - State goes to IDLE; out_valid=0, busy=0, done=0.
  - mem_rd_addr=0, element index=0, word register=0, words-remaining=0.
  - Reset mid-transfer aborts immediately. No done pulse; no further elements.
- States: IDLE, FETCH, EMIT, DONE.
- IDLE:
  - start=1 and length≠0 → latch base and length; mem_rd_addr=base_address; busy=1; go to FETCH.
  - start=1 and length=0 → go to DONE directly (done pulses next cycle); no elements emitted.
- FETCH (one cycle):
  - word_reg ← mem_rd_data; mem_rd_addr ← mem_rd_addr+1; words-remaining ← length−1; element index ← 0; go to EMIT.
- EMIT:
  - out_valid=1; out_data = word_reg[idx*element_width +: element_width]. Element 0 is the LSBs.
  - out_data, out_elem_index and out_last stay stable while out_valid=1 and out_ready=0.
  - On handshake (out_valid & out_ready):
    - idx < no_of_units−1 → idx+1.
    - idx = no_of_units−1 and words-remaining>0 → prefetch: word_reg ← mem_rd_data (already addressed); mem_rd_addr+1; words-remaining−1; idx ← 0. No bubble, so throughput is 1 element/cycle after FETCH.
    - idx = no_of_units−1 and words-remaining=0 → go to DONE.
- out_last = out_valid & (words-remaining=0) & (idx=no_of_units−1).
- DONE: done=1 for exactly one cycle; busy stays 1 during this cycle; next state IDLE with busy=0.
- start while busy is ignored. No queuing.
- Address arithmetic wraps modulo 2^memories_address_width (e.g. base=all-ones, length=2 reads all-ones then 0).
- mem_rd_addr changes only in FETCH, on a prefetch handshake, or on start acceptance. It is held otherwise.
- Memory contents must not be written in the range being read during a transfer. The consequences of doing so are the caller's problem.
- Latency from accepted start to first out_valid: 2 cycles. Total transfer with out_ready held 1: 2 + length*no_of_units cycles to the done pulse.

Test Plan:
- Basic: preload word 5 = elements {8..1} (element0=1); start, base=5, length=1, out_ready=1.
  - → out_valid rises 2 cycles after start.
  - → out_data 1,2,…,8 with idx 0..7 on consecutive cycles.
  - → out_last only on value 8; done one cycle later; busy low the cycle after that.
- Multi-word throughput: base=10, length=3, out_ready=1.
  - → 24 contiguous valid beats with no bubble at word boundaries.
  - → mem_rd_addr sequence 10,11,12,13; out_last on beat 24.
- Backpressure: length=1, out_ready toggling 1,0,0,1,…
  - → out_data/idx stable during stalls; exactly 8 elements, none duplicated or dropped.
- Zero length and busy-start: start with length=0.
  - → done pulse next cycle, out_valid never 1.
  - Start again with length=2; pulse start mid-transfer with base=99.
  - → ignored; the 16 elements come from the original range only.
- Wrap and reset:
  - base=2^20−1, length=2 → reads address 0xFFFFF then 0x00000.
  - Assert rst_n=0 at the 5th beat → next cycle out_valid=0, busy=0, no done pulse, mem_rd_addr=0.
